load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Requester-side partner of the data memory: takes one load/store per handshake from the
//  execute stage and formats byte lanes and write strobes. Drives a fixed-latency word
//  memory, sign/zero-extends load data and returns one response per accepted request.
//  Sits between the EX/MEM pipeline register and the data memory; the pipeline stalls on ~req_ready.
// PARAMETERS
//  DATA_W      32  data path width (only 32 supported)
//  DM_ADDRESS  9   byte-address bits forwarded to memory; upper addr bits ignored
//  MEM_LAT     1   cycles from mem_raddr valid to mem_rdata valid (1..4)
// PORTS
//  clk         in   1           single clock, all state on rising edge
//  reset       in   1           synchronous, active-high
//  req_valid   in   1           request present
//  req_ready   out  1           1 only in IDLE; accept = req_valid & req_ready
//  MemRead     in   1           load request (from control unit)
//  MemWrite    in   1           store request (from control unit)
//  Funct3      in   3           instr[14:12]: access size/sign
//  addr        in   DATA_W      byte address (ALU result)
//  wd          in   DATA_W      store data, value in low bits
//  rsp_valid   out  1           one-cycle pulse per accepted request
//  rd          out  DATA_W      extended load data; 0 for stores/errors
//  err         out  1           qualifies rsp_valid: misaligned, illegal Funct3, or Rd&Wr both set
//  mem_raddr   out  DM_ADDRESS  word-aligned read address ([1:0]=0)
//  mem_waddr   out  DM_ADDRESS  word-aligned write address
//  mem_wdata   out  DATA_W      lane-aligned store data
//  mem_wr      out  4           byte write strobes, bit i = byte lane i
//  mem_rdata   in   DATA_W      memory read word
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; rsp_valid=0, err=0, rd=0, mem_wr=0, mem addrs/wdata=0.
//  FSM IDLE -> {STORE | LOAD_WAIT | ERROR} on accept; all -> RESP -> IDLE.
//   accept with MemRead=MemWrite=0: no-op, stays IDLE, no response.
//   STORE: 1 cycle, mem_wr = strobe, mem_waddr/mem_wdata held from latched request.
//   LOAD_WAIT: mem_raddr held; counter runs MEM_LAT cycles, then mem_rdata captured.
//   ERROR: no memory access, mem_wr stays 0.
//   RESP: rsp_valid=1 one cycle with rd/err; req_ready=0 until back in IDLE.
//  Latency accept->rsp_valid: store 2, load MEM_LAT+1, error 2 cycles. No back-to-back accepts.
//  Request fields latched at accept; input changes afterwards are ignored.
//  Funct3 map: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
//  Errors: 011/110/111 any; 100/101 on store; half with addr[0]=1; word with addr[1:0]!=0;
//   MemRead&MemWrite both 1. Errored response: rd=0, err=1.
//  Store lanes: SB strobe 0001<<addr[1:0], wdata={4{wd[7:0]}}; SH strobe 0011<<{addr[1],1'b0},
//   wdata={2{wd[15:0]}}; SW strobe 1111, wdata=wd.
//  Load extract: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend.
//  mem_wr is 0 in every state but STORE; mem_wr never asserted after reset until a new accept.
//  Reset mid-operation: next edge -> IDLE, pending response dropped, no rsp_valid, mem_wr=0.
// STRUCTURE
//  lsu_pkg: Funct3 localparams (F3_B,F3_H,F3_W,F3_BU,F3_HU), lsu_state_t enum
//   {IDLE,STORE,LOAD_WAIT,ERROR,RESP}, lane-strobe helper function.
//  Sub-module lsu_lane_fmt (combinational): store align/strobe + load extract/extend;
//   FSM, latency counter and request latch stay in load_store_unit.
// TESTING
//  SW addr=0x10 wd=0xDEADBEEF -> 1 cycle later mem_wr=1111 mem_waddr=0x10; rsp_valid, err=0, rd=0.
//  SB addr=0x13 wd=0x000000A5 -> mem_wr=1000, mem_wdata=0xA5A5A5A5; then LW 0x10 -> rd=0xA5ADBEEF.
//  mem word 0x80F1_7F02 @0x20: LB 0x23->0xFFFFFF80, LBU 0x23->0x00000080, LH 0x20->0x00007F02, LHU 0x22->0x000080F1.
//  LW addr=0x22 and SH addr=0x21 -> err=1, rd=0, mem_wr stays 0000, rsp 2 cycles after accept.
//  MEM_LAT=3: LW accept -> rsp_valid exactly 4 cycles later; req_ready=0 throughout.
//  reset asserted in LOAD_WAIT -> no rsp_valid, req_ready=1 next cycle, next SW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM states,
// the latched request record and the byte-lane strobe helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    LOAD_WAIT,
    ERROR,
    RESP
  } lsu_state_t;

  // Only the fields the load extractor needs after accept are kept.
  typedef struct packed {
    logic [2:0] f3;
    logic [1:0] off;
  } lsu_req_t;

  function automatic logic [3:0] lane_strobe(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-stage <-> load/store unit request/response channel.
interface lsu_if #(parameter int DATA_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              MemRead;
  logic              MemWrite;
  logic [2:0]        Funct3;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wd;
  logic              rsp_valid;
  logic [DATA_W-1:0] rd;
  logic              err;

  modport master (
    output req_valid, MemRead, MemWrite, Funct3, addr, wd,
    input  req_ready, rsp_valid, rd, err
  );

  modport slave (
    input  req_valid, MemRead, MemWrite, Funct3, addr, wd,
    output req_ready, rsp_valid, rd, err
  );
endinterface

// File: rtl/lsu_lane_fmt.sv
// Combinational byte-lane formatting: store replication/strobes on the request
// side, load lane extraction and sign/zero extension on the response side.
module lsu_lane_fmt
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        st_f3,
  input  logic [1:0]        st_off,
  input  logic [DATA_W-1:0] wd,
  output logic [3:0]        strb,
  output logic [DATA_W-1:0] wdata,
  input  logic [2:0]        ld_f3,
  input  logic [1:0]        ld_off,
  input  logic [DATA_W-1:0] rword,
  output logic [DATA_W-1:0] ld_data
);
  localparam int NUM_LANES = DATA_W / 8;

  logic [NUM_LANES-1:0][7:0] wlanes;
  logic [7:0]                bsel;
  logic [15:0]               hsel;

  assign strb = lane_strobe(st_f3, st_off);

  // Byte stores feed every lane from wd[7:0], halves alternate the low two bytes.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wlanes[i] = (st_f3[1:0] == 2'b00) ? wd[7:0] :
                       (st_f3[1:0] == 2'b01) ? wd[8*(i%2) +: 8] :
                                               wd[8*i +: 8];
  end
  assign wdata = wlanes;

  assign bsel = rword[8*ld_off +: 8];
  assign hsel = rword[16*ld_off[1] +: 16];

  always_comb begin
    ld_data = rword;
    case (ld_f3)
      F3_B:    ld_data = {{(DATA_W-8){bsel[7]}}, bsel};
      F3_BU:   ld_data = {{(DATA_W-8){1'b0}}, bsel};
      F3_H:    ld_data = {{(DATA_W-16){hsel[15]}}, hsel};
      F3_HU:   ld_data = {{(DATA_W-16){1'b0}}, hsel};
      default: ld_data = rword;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request per handshake, fixed-latency word memory,
// single registered response per accepted load/store.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  lsu_if.slave                  bus,
  output logic [DM_ADDRESS-1:0] mem_raddr,
  output logic [DM_ADDRESS-1:0] mem_waddr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [3:0]            mem_wr,
  input  logic [DATA_W-1:0]     mem_rdata
);
  lsu_state_t        state;
  lsu_req_t          req_q;
  logic [1:0]        cnt;
  logic              bad;
  logic              accept;
  logic [3:0]        st_strb;
  logic [DATA_W-1:0] st_wdata;
  logic [DATA_W-1:0] ld_ext;
  logic              unused_hi;

  assign unused_hi = ^bus.addr[DATA_W-1:DM_ADDRESS];
  assign accept    = bus.req_valid & bus.req_ready;

  lsu_lane_fmt #(.DATA_W(DATA_W)) u_fmt (
    .st_f3   (bus.Funct3),
    .st_off  (bus.addr[1:0]),
    .wd      (bus.wd),
    .strb    (st_strb),
    .wdata   (st_wdata),
    .ld_f3   (req_q.f3),
    .ld_off  (req_q.off),
    .rword   (mem_rdata),
    .ld_data (ld_ext)
  );

  always_comb begin
    bad = 1'b0;
    case (bus.Funct3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = bus.addr[0];
      F3_W:        bad = |bus.addr[1:0];
      default:     bad = 1'b1;
    endcase
    if (bus.MemWrite && bus.Funct3[2])  bad = 1'b1;
    if (bus.MemRead  && bus.MemWrite)   bad = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      req_q         <= '0;
      cnt           <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.err       <= 1'b0;
      bus.rd        <= '0;
      mem_wr        <= '0;
      mem_raddr     <= '0;
      mem_waddr     <= '0;
      mem_wdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.rsp_valid <= 1'b0;
          if (accept && (bus.MemRead || bus.MemWrite)) begin
            req_q         <= '{f3: bus.Funct3, off: bus.addr[1:0]};
            bus.req_ready <= 1'b0;
            if (bad) begin
              state <= ERROR;
            end else if (bus.MemWrite) begin
              state     <= STORE;
              mem_wr    <= st_strb;
              mem_waddr <= {bus.addr[DM_ADDRESS-1:2], 2'b00};
              mem_wdata <= st_wdata;
            end else begin
              state     <= LOAD_WAIT;
              mem_raddr <= {bus.addr[DM_ADDRESS-1:2], 2'b00};
              cnt       <= '0;
            end
          end
        end
        STORE: begin
          mem_wr        <= '0;
          bus.rsp_valid <= 1'b1;
          bus.err       <= 1'b0;
          bus.rd        <= '0;
          state         <= RESP;
        end
        // Memory word is valid on the MEM_LAT-th cycle of holding mem_raddr.
        LOAD_WAIT: begin
          if (cnt == 2'(MEM_LAT - 1)) begin
            bus.rsp_valid <= 1'b1;
            bus.err       <= 1'b0;
            bus.rd        <= ld_ext;
            state         <= RESP;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        ERROR: begin
          bus.rsp_valid <= 1'b1;
          bus.err       <= 1'b1;
          bus.rd        <= '0;
          state         <= RESP;
        end
        RESP: begin
          bus.rsp_valid <= 1'b0;
          bus.err       <= 1'b0;
          bus.rd        <= '0;
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          state         <= IDLE;
          mem_wr        <= '0;
          bus.rsp_valid <= 1'b0;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
